// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
// Module   : life_pkg
// Purpose  : Shared constants, FSM state type and cell-index helper for the
//            Game of Life step engine (8x8 grid, B3/S23 rule).
// Contents : ROWS/COLS/CELLS geometry, index widths, rule thresholds,
//            state_t {IDLE, SCAN, COMMIT}, split_idx() row/column splitter.
// Revision : 1.0 - initial release
// ============================================================================
package life_pkg;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int CELLS = ROWS * COLS;
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int IDX_W = ROW_W + COL_W;

    // B3/S23: birth on exactly 3 neighbours, survival on 2 or 3
    localparam logic [3:0] BIRTH_N    = 4'd3;
    localparam logic [3:0] SURVIVE_LO = 4'd2;
    localparam logic [3:0] SURVIVE_HI = 4'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } cell_rc_t;

    // Cell index layout is row-major: upper bits select the row
    function automatic cell_rc_t split_idx(input logic [IDX_W-1:0] idx);
        cell_rc_t rc;
        rc.row = idx[IDX_W-1:COL_W];
        rc.col = idx[COL_W-1:0];
        return rc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/life_neighbour_count.sv
`default_nettype none
// ============================================================================
// Module   : life_neighbour_count
// Purpose  : Combinational count of live neighbours (0..8) of one cell of the
//            snapshot grid.
// Ports    : i_snap [CELLS-1:0]  snapshot grid, bit i = row i[5:3], col i[2:0]
//            i_idx  [IDX_W-1:0]  cell being evaluated
//            o_n    [3:0]        live neighbour count
// Options  : LIFE_TORUS_EN - neighbour coordinates wrap modulo ROWS/COLS
//            (toroidal grid); otherwise off-grid neighbours read as dead.
// Revision : 1.0 - initial release
// ============================================================================
module life_neighbour_count
    import life_pkg::*;
(
    input  logic [CELLS-1:0] i_snap,
    input  logic [IDX_W-1:0] i_idx,
    output logic [3:0]       o_n
);

    cell_rc_t   w_rc;
    logic [8:0] w_live;

    assign w_rc = split_idx(i_idx);

    // Offsets enumerated as a 3x3 window; k==4 is the cell itself
    for (genvar k = 0; k < 9; k++) begin : g_nb
        localparam int c_dr = k / 3 - 1;
        localparam int c_dc = k % 3 - 1;
        if (k == 4) begin : g_self
            assign w_live[k] = 1'b0;
        end else begin : g_off
`ifdef LIFE_TORUS_EN
            // Truncated arithmetic wraps naturally for power-of-two sizes
            logic [ROW_W-1:0] w_r;
            logic [COL_W-1:0] w_c;
            assign w_r       = w_rc.row + ROW_W'(c_dr);
            assign w_c       = w_rc.col + COL_W'(c_dc);
            assign w_live[k] = i_snap[{w_r, w_c}];
`else
            // One extra bit: -1 becomes all-ones and ROWS sets the MSB, so the
            // MSB alone flags an off-grid coordinate in either direction
            logic [ROW_W:0] w_r;
            logic [COL_W:0] w_c;
            assign w_r       = {1'b0, w_rc.row} + (ROW_W+1)'(c_dr);
            assign w_c       = {1'b0, w_rc.col} + (COL_W+1)'(c_dc);
            assign w_live[k] = ~w_r[ROW_W] & ~w_c[COL_W]
                             & i_snap[{w_r[ROW_W-1:0], w_c[COL_W-1:0]}];
`endif
        end
    end

    always_comb begin
        o_n = 4'd0;
        for (int k = 0; k < 9; k++) begin
            o_n = o_n + {3'd0, w_live[k]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/life_step_engine.sv
`default_nettype none
// ============================================================================
// Module   : life_step_engine
// Purpose  : Computes one Game of Life generation (B3/S23) of an 8x8 grid.
//            On start the grid is snapshotted, one cell is evaluated per
//            clock (64 cycles), then the result is committed with a one-cycle
//            done pulse, generation count and stable/extinct flags.
// Ports    : clka         system clock (rising edge)
//            rst          synchronous active-high reset
//            i_start      request a step (sampled only in IDLE)
//            i_clear      synchronous abort/clear, same effect as rst
//            i_grid_in    current grid, bit i = row i[5:3], col i[2:0]
//            o_grid_out   last committed generation
//            o_busy       step in progress (SCAN or COMMIT)
//            o_done       one-cycle pulse when o_grid_out updates
//            o_stable     last generation equals its predecessor
//            o_extinct    last generation is empty
//            o_gen_count  committed generations (wraps)
// Options  : LIFE_TORUS_EN - toroidal neighbourhood (see life_neighbour_count)
// Revision : 1.0 - initial release
// ============================================================================
module life_step_engine #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16
) (
    input  logic                   clka,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic                   i_clear,
    input  logic [ROWS*COLS-1:0]   i_grid_in,
    output logic [ROWS*COLS-1:0]   o_grid_out,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_stable,
    output logic                   o_extinct,
    output logic [GEN_W-1:0]       o_gen_count
);

    import life_pkg::*;

    localparam int c_cells = ROWS * COLS;
    localparam int c_idx_w = $clog2(c_cells);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cells-1:0]   r_snap;
    logic [c_cells-1:0]   r_next;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_cells-1:0]   r_grid_out;
    logic                 r_done;
    logic                 r_stable;
    logic                 r_extinct;
    logic [GEN_W-1:0]     r_gen_count;

    logic                 w_clr;
    logic [3:0]           w_n;
    logic                 w_cell_nxt;
    logic                 w_last;

    assign w_clr  = rst | i_clear;
    assign w_last = &r_idx;

    life_neighbour_count u_count (
        .i_snap (r_snap),
        .i_idx  (r_idx),
        .o_n    (w_n)
    );

    assign w_cell_nxt = (w_n == BIRTH_N)
                      | (r_snap[r_idx] & (w_n >= SURVIVE_LO) & (w_n <= SURVIVE_HI));

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clka) begin
        if (w_clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = SCAN;
            SCAN:    if (w_last)  w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clka) begin
        if (w_clr) begin
            r_snap      <= '0;
            r_next      <= '0;
            r_idx       <= '0;
            r_grid_out  <= '0;
            r_done      <= 1'b0;
            r_stable    <= 1'b0;
            r_extinct   <= 1'b0;
            r_gen_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_snap <= i_grid_in;
                        r_next <= '0;
                        r_idx  <= '0;
                    end
                end
                SCAN: begin
                    r_next[r_idx] <= w_cell_nxt;
                    r_idx         <= r_idx + 1'b1;
                end
                COMMIT: begin
                    r_grid_out  <= r_next;
                    r_stable    <= (r_next == r_snap);
                    r_extinct   <= (r_next == '0);
                    r_gen_count <= r_gen_count + 1'b1;
                    r_done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_grid_out  = r_grid_out;
    assign o_busy      = (r_state != IDLE);
    assign o_done      = r_done;
    assign o_stable    = r_stable;
    assign o_extinct   = r_extinct;
    assign o_gen_count = r_gen_count;

endmodule
`default_nettype wire

// File: tb/tb_life_step_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_life_step_engine
// Purpose  : Self-checking bench for life_step_engine: directed pattern table,
//            randomized grids against a behavioural Life model, handshake,
//            back-to-back and abort sequences.
// Options  : LIFE_TORUS_EN selects the toroidal reference model/expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_life_step_engine;

    localparam int GEN_W = 16;
`ifdef LIFE_TORUS_EN
    localparam bit c_torus = 1'b1;
`else
    localparam bit c_torus = 1'b0;
`endif

    logic              clka      = 1'b0;
    logic              rst       = 1'b1;
    logic              i_start   = 1'b0;
    logic              i_clear   = 1'b0;
    logic [63:0]       i_grid_in = '0;
    logic [63:0]       o_grid_out;
    logic              o_busy;
    logic              o_done;
    logic              o_stable;
    logic              o_extinct;
    logic [GEN_W-1:0]  o_gen_count;

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [GEN_W-1:0]  exp_gen  = '0;

    always #5 clka = ~clka;

    life_step_engine #(.ROWS(8), .COLS(8), .GEN_W(GEN_W)) dut (
        .clka        (clka),
        .rst         (rst),
        .i_start     (i_start),
        .i_clear     (i_clear),
        .i_grid_in   (i_grid_in),
        .o_grid_out  (o_grid_out),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_stable    (o_stable),
        .o_extinct   (o_extinct),
        .o_gen_count (o_gen_count)
    );

    // Reference: direct application of B3/S23 over row/column coordinates
    function automatic logic [63:0] model_step(input logic [63:0] g);
        logic [63:0] res;
        res = '0;
        for (int row = 0; row < 8; row++) begin
            for (int col = 0; col < 8; col++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr;
                        int cc;
                        rr = row + dr;
                        cc = col + dc;
                        if (c_torus) begin
                            rr = (rr + 8) % 8;
                            cc = (cc + 8) % 8;
                        end
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            n += int'(g[rr*8 + cc]);
                    end
                end
                res[row*8 + col] = (n == 3) || (g[row*8 + col] && n == 2);
            end
        end
        return res;
    endfunction

    function automatic logic [63:0] bit3(input int a, input int b, input int c);
        logic [63:0] v;
        v = '0;
        v[a] = 1'b1;
        v[b] = 1'b1;
        v[c] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one start pulse and observe 70 cycles. Optional extra start
    // pulses at cycles x1/x2 (0 = none); grid_in is scrambled after start.
    task automatic run_step(input logic [63:0] g, input int x1, input int x2,
                            output int done_at, output int busy_n, output int done_n);
        @(negedge clka);
        i_grid_in = g;
        i_start   = 1'b1;
        @(negedge clka);
        i_start   = 1'b0;
        i_grid_in = {$urandom, $urandom};
        done_at = 0;
        busy_n  = 0;
        done_n  = 0;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            if (cyc > 1) @(negedge clka);
            if (o_busy) busy_n++;
            if (o_done) begin
                done_n++;
                if (done_at == 0) done_at = cyc;
            end
            i_start = (cyc == x1) || (cyc == x2);
        end
        i_start = 1'b0;
    endtask

    task automatic step_check(input string tag, input logic [63:0] g, input logic [63:0] exp_out,
                              input logic exp_st, input logic exp_ex, input int x1, input int x2);
        int done_at, busy_n, done_n;
        run_step(g, x1, x2, done_at, busy_n, done_n);
        exp_gen = exp_gen + 1'b1;
        check({tag, " grid"},    o_grid_out, exp_out);
        check({tag, " stable"},  64'(o_stable), 64'(exp_st));
        check({tag, " extinct"}, 64'(o_extinct), 64'(exp_ex));
        check({tag, " gen"},     64'(o_gen_count), 64'(exp_gen));
        check({tag, " done_at"}, 64'(done_at), 64'd66);
        check({tag, " busy_n"},  64'(busy_n), 64'd65);
        check({tag, " done_n"},  64'(done_n), 64'd1);
    endtask

    task automatic abort_test(input bit use_clear);
        int done_n;
        string tag;
        tag = use_clear ? "abort_clear" : "abort_rst";
        @(negedge clka);
        i_grid_in = bit3(26, 27, 28);
        i_start   = 1'b1;
        @(negedge clka);
        i_start = 1'b0;
        repeat (30) @(negedge clka);   // scanning cell 30 now
        check({tag, " busy_mid"}, 64'(o_busy), 64'd1);
        if (use_clear) i_clear = 1'b1; else rst = 1'b1;
        @(negedge clka);
        check({tag, " busy"},    64'(o_busy), 64'd0);
        check({tag, " grid"},    o_grid_out, 64'd0);
        check({tag, " gen"},     64'(o_gen_count), 64'd0);
        check({tag, " done"},    64'(o_done), 64'd0);
        check({tag, " stable"},  64'(o_stable), 64'd0);
        check({tag, " extinct"}, 64'(o_extinct), 64'd0);
        i_clear = 1'b0;
        rst     = 1'b0;
        exp_gen = '0;
        done_n  = 0;
        repeat (80) begin
            @(negedge clka);
            if (o_done) done_n++;
        end
        check({tag, " no_done"},   64'(done_n), 64'd0);
        check({tag, " grid_hold"}, o_grid_out, 64'd0);
    endtask

    typedef struct {
        logic [63:0] grid;
        logic [63:0] exp_out;
        logic        exp_st;
        logic        exp_ex;
    } vec_t;

    vec_t vt [5];

    initial begin
        logic [63:0] g;
        logic [63:0] e;
        int t, first, second;

        vt[0] = '{bit3(26, 27, 28), bit3(19, 27, 35), 1'b0, 1'b0};
        vt[1] = '{bit3(19, 27, 35), bit3(26, 27, 28), 1'b0, 1'b0};
        vt[2] = '{64'h0303, 64'h0303, 1'b1, 1'b0};
        vt[3] = '{64'd1 << 36, 64'd0, 1'b0, 1'b1};
`ifdef LIFE_TORUS_EN
        vt[4] = '{bit3(7, 0, 1), bit3(56, 0, 8), 1'b0, 1'b0};
`else
        vt[4] = '{bit3(7, 0, 1), 64'd0, 1'b0, 1'b1};
`endif

        // Reset state
        repeat (3) @(negedge clka);
        check("rst grid",    o_grid_out, 64'd0);
        check("rst busy",    64'(o_busy), 64'd0);
        check("rst done",    64'(o_done), 64'd0);
        check("rst stable",  64'(o_stable), 64'd0);
        check("rst extinct", 64'(o_extinct), 64'd0);
        check("rst gen",     64'(o_gen_count), 64'd0);
        rst = 1'b0;

        // Directed patterns (second blinker step brings gen_count to 2)
        for (int i = 0; i < 5; i++)
            step_check($sformatf("vec%0d", i), vt[i].grid, vt[i].exp_out,
                       vt[i].exp_st, vt[i].exp_ex, 0, 0);

        // Start pulses while busy must be ignored
        g = 64'h0000_1C00_0038_0000;
        e = model_step(g);
        step_check("handshake", g, e, e == g, e == 64'd0, 10, 40);

        // Randomized grids against the model
        for (int i = 0; i < 20; i++) begin
            g = {$urandom, $urandom} & {$urandom, $urandom};
            if (i % 3 == 0) g = g & {$urandom, $urandom};
            e = model_step(g);
            step_check($sformatf("rand%0d", i), g, e, e == g, e == 64'd0,
                       (i % 4 == 0) ? int'($urandom_range(2, 64)) : 0, 0);
        end

        // Start held high: back-to-back steps every 66 cycles
        g = {$urandom, $urandom};
        @(negedge clka);
        i_grid_in = g;
        i_start   = 1'b1;
        t = 0; first = 0; second = 0;
        while (second == 0 && t < 300) begin
            @(negedge clka);
            t++;
            if (o_done) begin
                if (first == 0) first = t;
                else begin
                    second  = t;
                    i_start = 1'b0;
                end
            end
        end
        i_start = 1'b0;
        exp_gen = exp_gen + 2'd2;
        repeat (4) @(negedge clka);
        check("b2b first",   64'(first), 64'd66);
        check("b2b spacing", 64'(second - first), 64'd66);
        check("b2b busy",    64'(o_busy), 64'd0);
        check("b2b grid",    o_grid_out, model_step(g));
        check("b2b gen",     64'(o_gen_count), 64'(exp_gen));

        // Aborts mid-scan (make outputs non-zero first)
        step_check("pre_rst", vt[0].grid, vt[0].exp_out, 1'b0, 1'b0, 0, 0);
        abort_test(1'b0);
        step_check("pre_clr", vt[0].grid, vt[0].exp_out, 1'b0, 1'b0, 0, 0);
        abort_test(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
